ram_responder: RTL and testbench

Word-addressed RAM model that answers the memory controller's RAM-side request interface: `ramREN`/`ramWEN`/`ramaddr`/`ramstore` in, `ramload`/`ramstate` out. It is the responder end of that handshake. It inserts a programmable number of BUSY cycles, then signals one ACCESS cycle in which read data is valid or a write commits. It sits below the memory controller in the system and in its unit benches, and replaces the fixed-latency RAM when latency sweeps or error injection are needed.

---
 rtl/cpu_types_pkg.sv | 6 +
 rtl/ram_word_array.sv | 20 ++
 rtl/ram_responder.sv | 91 +++++++++
 tb/tb_ram_responder.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: word and RAM response state.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  localparam int RAM_LAT_MAX = 15;
endpackage

// File: rtl/ram_word_array.sv
// 32-bit word storage: one synchronous write port and one asynchronous read port. Contents are not reset.
module ram_word_array
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              wen,
  input  logic [ADDR_W-1:0] widx,
  input  word_t             wdata,
  input  logic [ADDR_W-1:0] ridx,
  output word_t             rdata
);
  word_t mem [2**ADDR_W];

  always_ff @(posedge clk)
    if (wen) mem[widx] <= wdata;

  assign rdata = mem[ridx];
endmodule

// File: rtl/ram_responder.sv
// RAM-side responder with programmable latency: FREE -> BUSY x LAT -> ACCESS -> FREE, and ERROR for bad requests.
module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int LAT    = 2,
  parameter int ADDR_W = 14
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      ramREN,
  input  logic      ramWEN,
  input  word_t     ramaddr,
  input  word_t     ramstore,
  output word_t     ramload,
  output ramstate_t ramstate
);
  ramstate_t         state, nxt;
  logic [3:0]        cnt, cnt_d;
  logic              lat_wr, lat_wr_d;
  logic [ADDR_W-1:0] lat_idx, lat_idx_d;
  word_t             lat_data, lat_data_d;
  word_t             rdata;
  logic              req, bad, abort;

  assign req = ramREN | ramWEN;
  assign bad = req & ((ramREN & ramWEN) | (ramaddr[1:0] != 2'b00) |
                      ((ramaddr >> (ADDR_W + 2)) != '0));
  // Controller must hold the exact same op and address for the whole BUSY window.
  assign abort = !req || (ramWEN != lat_wr) || (ramREN == lat_wr) ||
                 (ramaddr != {{(30-ADDR_W){1'b0}}, lat_idx, 2'b00});

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= FREE;
      cnt      <= '0;
      lat_wr   <= 1'b0;
      lat_idx  <= '0;
      lat_data <= '0;
    end else begin
      state    <= nxt;
      cnt      <= cnt_d;
      lat_wr   <= lat_wr_d;
      lat_idx  <= lat_idx_d;
      lat_data <= lat_data_d;
    end
  end

  always_comb begin
    nxt        = state;
    cnt_d      = cnt;
    lat_wr_d   = lat_wr;
    lat_idx_d  = lat_idx;
    lat_data_d = lat_data;
    case (state)
      FREE: begin
        if (bad) nxt = ERROR;
        else if (req) begin
          lat_wr_d   = ramWEN;
          lat_idx_d  = ramaddr[ADDR_W+1:2];
          lat_data_d = ramstore;
          if (LAT == 0) nxt = ACCESS;
          else begin
            nxt   = BUSY;
            cnt_d = 4'(LAT - 1);
          end
        end
      end
      BUSY: begin
        if (abort) nxt = FREE;
        else if (cnt == 4'd0) nxt = ACCESS;
        else cnt_d = cnt - 4'd1;
      end
      ACCESS: nxt = FREE;
      ERROR: if (!req) nxt = FREE;
      default: nxt = FREE;
    endcase
  end

  // Write enable derives from the async-reset state, so a reset inside ACCESS suppresses the commit.
  ram_word_array #(.ADDR_W(ADDR_W)) u_arr (
    .clk   (CLK),
    .wen   (state == ACCESS && lat_wr),
    .widx  (lat_idx),
    .wdata (lat_data),
    .ridx  (lat_idx),
    .rdata (rdata)
  );

  assign ramload  = (state == ACCESS && !lat_wr) ? rdata : '0;
  assign ramstate = state;
endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: LAT=2 instance for most scenarios, LAT=0 instance for back-to-back writes.
module tb_ram_responder;
  import cpu_types_pkg::*;

  logic      CLK = 1'b0, RST = 1'b1;
  logic      ramREN = 1'b0, ramWEN = 1'b0;
  word_t     ramaddr = '0, ramstore = '0;
  word_t     load2, load0;
  ramstate_t st2, st0;
  int        total = 0, bad = 0;
  word_t     rd;

  always #5 CLK = ~CLK;

  ram_responder #(.LAT(2), .ADDR_W(14)) dut2 (
    .CLK(CLK), .RST(RST), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(load2), .ramstate(st2));

  ram_responder #(.LAT(0), .ADDR_W(14)) dut0 (
    .CLK(CLK), .RST(RST), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(load0), .ramstate(st0));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic ren, input logic wen, input word_t a, input word_t d);
    ramREN = ren; ramWEN = wen; ramaddr = a; ramstore = d;
  endtask

  // Full transaction from FREE; sel picks the LAT=0 instance. Returns ramload seen in ACCESS.
  task automatic run_op(input bit sel, input bit wr, input word_t a, input word_t d, output word_t r);
    int n = 0;
    drive(!wr, wr, a, d);
    tick;
    while ((sel ? st0 : st2) != ACCESS && n < 20) begin tick; n++; end
    if (n >= 20) chk("op_timeout", 32'(sel ? st0 : st2), 32'(ACCESS));
    r = sel ? load0 : load2;
    drive(0, 0, '0, '0);
    tick;
  endtask

  initial begin
    #2;
    chk("rst_state", 32'(st2), 32'(FREE));
    chk("rst_load", load2, 32'h0);
    #10 RST = 1'b0;
    tick;

    // 1: write timing, then read-back visible only in ACCESS
    chk("s1_t0", 32'(st2), 32'(FREE));
    drive(0, 1, 32'h40, 32'hDEADBEEF);
    tick; chk("s1_t1", 32'(st2), 32'(BUSY));
    tick; chk("s1_t2", 32'(st2), 32'(BUSY));
    tick; chk("s1_t3", 32'(st2), 32'(ACCESS));
    chk("s1_wload", load2, 32'h0);
    drive(0, 0, '0, '0);
    tick; chk("s1_t4", 32'(st2), 32'(FREE));
    drive(1, 0, 32'h40, '0);
    chk("s1_rl0", load2, 32'h0);
    tick; chk("s1_rl1", load2, 32'h0);
    tick; chk("s1_rl2", load2, 32'h0);
    tick; chk("s1_racc", 32'(st2), 32'(ACCESS));
    chk("s1_rdata", load2, 32'hDEADBEEF);
    drive(0, 0, '0, '0);
    tick; chk("s1_rl4", load2, 32'h0);

    // 2: both REN and WEN -> ERROR held while asserted
    drive(1, 1, 32'h40, 32'h12);
    for (int i = 0; i < 5; i++) begin tick; chk("s2_err", 32'(st2), 32'(ERROR)); end
    drive(0, 0, '0, '0);
    tick; chk("s2_free", 32'(st2), 32'(FREE));
    run_op(0, 0, 32'h40, '0, rd); chk("s2_read", rd, 32'hDEADBEEF);

    // 3: address change in second BUSY aborts, then restarts at the new address
    run_op(0, 1, 32'h80, 32'h80808080, rd);
    drive(0, 1, 32'h80, 32'h11111111);
    tick; chk("s3_b1", 32'(st2), 32'(BUSY));
    tick; chk("s3_b2", 32'(st2), 32'(BUSY));
    ramaddr = 32'h84;
    tick; chk("s3_abort", 32'(st2), 32'(FREE));
    tick; chk("s3_nb1", 32'(st2), 32'(BUSY));
    tick; chk("s3_nb2", 32'(st2), 32'(BUSY));
    tick; chk("s3_nacc", 32'(st2), 32'(ACCESS));
    drive(0, 0, '0, '0);
    tick;
    run_op(0, 0, 32'h80, '0, rd); chk("s3_old80", rd, 32'h80808080);
    run_op(0, 0, 32'h84, '0, rd); chk("s3_new84", rd, 32'h11111111);

    // 4: reset mid-BUSY and mid-ACCESS drops to FREE with no commit
    run_op(0, 1, 32'hC0, 32'h12345678, rd);
    drive(0, 1, 32'hC0, 32'hCAFE0000);
    tick; chk("s4_busy", 32'(st2), 32'(BUSY));
    RST = 1'b1;
    #1 chk("s4_rst_busy", 32'(st2), 32'(FREE));
    #1 RST = 1'b0;
    drive(0, 0, '0, '0);
    tick;
    drive(0, 1, 32'hC0, 32'hCAFE0000);
    tick; tick; tick; chk("s4_acc", 32'(st2), 32'(ACCESS));
    RST = 1'b1;
    #1 chk("s4_rst_acc", 32'(st2), 32'(FREE));
    #1 RST = 1'b0;
    drive(0, 0, '0, '0);
    tick;
    run_op(0, 0, 32'hC0, '0, rd); chk("s4_read", rd, 32'h12345678);

    // 5: misaligned and out-of-range reads; highest legal word works
    drive(1, 0, 32'h42, '0);
    tick; chk("s5_misal", 32'(st2), 32'(ERROR));
    drive(0, 0, '0, '0);
    tick; chk("s5_free1", 32'(st2), 32'(FREE));
    drive(1, 0, 32'h0001_0000, '0);
    tick; chk("s5_range", 32'(st2), 32'(ERROR));
    drive(0, 0, '0, '0);
    tick; chk("s5_free2", 32'(st2), 32'(FREE));
    run_op(0, 1, 32'h0000_FFFC, 32'h0BADF00D, rd);
    run_op(0, 0, 32'h0000_FFFC, '0, rd); chk("s5_top", rd, 32'h0BADF00D);

    // store data sampled at accept; later changes ignored
    drive(0, 1, 32'h200, 32'h5555_5555);
    tick; ramstore = 32'h6666_6666;
    tick; tick; chk("sd_acc", 32'(st2), 32'(ACCESS));
    drive(0, 0, '0, '0);
    tick;
    run_op(0, 0, 32'h200, '0, rd); chk("sd_read", rd, 32'h5555_5555);

    // 6: LAT=0 back-to-back writeback
    tick; tick;
    chk("s6_t0", 32'(st0), 32'(FREE));
    drive(0, 1, 32'h100, 32'hA);
    tick; chk("s6_acc1", 32'(st0), 32'(ACCESS));
    drive(0, 1, 32'h104, 32'hB);
    tick; chk("s6_free1", 32'(st0), 32'(FREE));
    tick; chk("s6_acc2", 32'(st0), 32'(ACCESS));
    drive(0, 0, '0, '0);
    tick; chk("s6_free2", 32'(st0), 32'(FREE));
    run_op(1, 0, 32'h100, '0, rd); chk("s6_rdA", rd, 32'hA);
    run_op(1, 0, 32'h104, '0, rd); chk("s6_rdB", rd, 32'hB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
